imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the byte-addressed, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream, from a boot/debug source such as a UART-to-word bridge.
- Breaks each word into four byte writes at consecutive addresses, least-significant byte at the lowest address, so the combinational fetch port reads back the original word.
- Holds the core in reset until the image is fully loaded.

Parameters:
- MEM_BYTES, 400, size of the target byte array; writes must stay within 0..MEM_BYTES-1.
- BASE_ADDR, 0, byte address of the first written word; must be a multiple of 4.
- CNT_W, 8, width of word_count; must hold MEM_BYTES/4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless the FSM is in IDLE, DONE or ERROR.
- in_valid  in  1  in_word/in_last are valid.
- in_word  in  32  instruction word.
- in_last  in  1  marks the final word of the image.
- in_ready  out  1  loader can accept a word this cycle.
- wr_en  out  1  byte write strobe to the instruction memory.
- wr_addr  out  32  byte address of the write.
- wr_byte  out  8  byte data.
- busy  out  1  a load is in progress.
- done  out  1  sticky: last load completed cleanly.
- error  out  1  sticky: last load overflowed.
- word_count  out  CNT_W  words fully written in the current or last load.
- cpu_hold  out  1  keep the core in reset; equals NOT done.

Behaviour:
- Reset values: FSM=IDLE; in_ready, wr_en, busy, done, error = 0; wr_addr=0; wr_byte=0; word_count=0; cpu_hold=1.
- Asserting reset mid-load aborts immediately and wr_en drops asynchronously. Memory keeps its partial contents.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - addr register <= BASE_ADDR; word_count <= 0; done <= 0; error <= 0; go to ACCEPT.
  - cpu_hold rises the cycle after start.
- ACCEPT:
  - busy=1 and in_ready=1 (registered state decode, no combinational path from in_valid).
  - On in_valid&&in_ready, if addr+4 > MEM_BYTES: discard the word, error <= 1, go to ERROR. No write occurs.
  - Otherwise: shift register <= in_word; last flag <= in_last; beat counter <= 0; go to WRITE.
- WRITE (busy=1, in_ready=0), four cycles, beats 0..3:
  - Each beat drives wr_en=1, wr_addr=addr, wr_byte=shift register[7:0]. wr_en/wr_addr/wr_byte are decoded from registered state, so they are valid for the whole cycle.
  - At each beat's clock edge: shift register shifts right by 8; addr increments by 1.
  - After beat 3, word_count increments. If the last flag is set, go to DONE (done <= 1); otherwise return to ACCEPT.
- Throughput: 5 cycles per word (1 accept + 4 writes). Latency from handshake to first wr_en is 1 cycle.
- DONE: busy=0, in_ready=0, done=1, cpu_hold=0. in_valid is ignored.
- ERROR: busy=0, in_ready=0, error=1, cpu_hold=1. Only start or reset leaves this state.
- start while busy: ignored, with no effect on state or counters.
- in_last on a word that lands exactly at byte MEM_BYTES-4: legal, ends in DONE.
- addr arithmetic is 32-bit unsigned. With legal parameters wrap-around is unreachable because the overflow check fires first.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0], reset to 0 and cleared on accepted start.
  - Each accepted, non-discarded word is added into it, modulo 2^32, at the ACCEPT handshake.
  - The value is stable in DONE, so software or the bench can verify the image.
- When undefined: the port and the adder are absent; all other behaviour is identical.

Decomposition:
- Shared package imem_pkg:
  - loader state enum (IDLE, ACCEPT, WRITE, DONE, ERROR);
  - constants BYTES_PER_WORD=4 and default IMEM_BYTES=400, shared with the instruction memory.
- No sub-module is needed; single FSM plus datapath.
- Optional: a tiny imem_byte_writer (4-beat serializer) if reused elsewhere.

Test Plan:
- Basic load: start; send 0x00500093 (last=0), then 0x00A00113 (last=1).
  - Expect byte writes 93,00,50,00 at addresses 0-3 and 13,01,A0,00 at addresses 4-7.
  - Then done=1, cpu_hold=0, word_count=2; fetch at address 4 returns 0x00A00113.
- Backpressure: in_valid held high with 3 queued words.
  - Expect in_ready high exactly 1 of every 5 cycles and exactly 12 wr_en pulses in order.
  - in_valid gaps of 0-7 cycles give the same memory image.
- Overflow: MEM_BYTES=8; send 3 words, none marked last.
  - Expect 8 byte writes, then the third word is discarded: error=1, done=0, cpu_hold=1, word_count=2.
- Reset mid-load: assert reset during WRITE beat 2 of word 0.
  - Expect wr_en=0 in the same cycle, all outputs at reset values, and a restart that works normally.
- start while busy: pulse start in WRITE and in ACCEPT.
  - Expect no change to addr or word_count, and the load completes as if no pulse occurred.
- Checksum (macro defined): load 0xFFFFFFFF and 0x00000002 (last).
  - Expect checksum=0x00000001 in DONE.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its byte-serial loader.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_BYTES     = 400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit words into the byte-wide instruction memory, LSB first, and
// holds the core in reset until the image is loaded. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_word,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [7:0]       wr_byte,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count,
    output logic             cpu_hold
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    ld_state_e        state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      shift_q, shift_d;
    logic             last_q, last_d;
    logic [1:0]       beat_q, beat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      csum_q, csum_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        last_d  = last_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    addr_d  = 32'(BASE_ADDR);
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    // A word that would not fit entirely is dropped, never half-written.
                    if (addr_q + 32'(BYTES_PER_WORD) > 32'(MEM_BYTES)) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        shift_d = in_word;
                        last_d  = in_last;
                        beat_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = csum_q + in_word;
`endif
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                shift_d = shift_q >> 8;
                addr_d  = addr_q + 32'd1;
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Pure decode of registered state, so reset drops the write strobe at once.
    assign in_ready   = (state_q == ST_ACCEPT);
    assign wr_en      = (state_q == ST_WRITE);
    assign busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign wr_addr    = wr_en ? addr_q : '0;
    assign wr_byte    = wr_en ? shift_q[7:0] : '0;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = cnt_q;
    assign cpu_hold   = ~done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven loads plus backpressure,
// overflow, mid-load reset, start-while-busy and (if enabled) checksum cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = '0;
    logic        in_last = 1'b0;
    logic        sel = 1'b0;

    logic a_in_ready, a_wr_en, a_busy, a_done, a_error, a_cpu_hold;
    logic [31:0] a_wr_addr;
    logic [7:0]  a_wr_byte, a_cnt;
    logic b_in_ready, b_wr_en, b_busy, b_done, b_error, b_cpu_hold;
    logic [31:0] b_wr_addr;
    logic [7:0]  b_wr_byte, b_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] a_csum, b_csum;
`endif

    logic o_in_ready, o_wr_en, o_busy, o_done, o_error, o_cpu_hold;
    logic [31:0] o_wr_addr;
    logic [7:0]  o_wr_byte, o_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mem [0:399];

    always #5 clk = ~clk;

    imem_loader u_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
        .in_word(in_word), .in_last(in_last), .in_ready(a_in_ready), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .wr_byte(a_wr_byte), .busy(a_busy), .done(a_done),
        .error(a_error), .word_count(a_cnt), .cpu_hold(a_cpu_hold)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(a_csum)
`endif
    );

    imem_loader #(.MEM_BYTES(8)) u_b (
        .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
        .in_word(in_word), .in_last(in_last), .in_ready(b_in_ready), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_byte(b_wr_byte), .busy(b_busy), .done(b_done),
        .error(b_error), .word_count(b_cnt), .cpu_hold(b_cpu_hold)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(b_csum)
`endif
    );

    always_comb begin
        o_in_ready = sel ? b_in_ready : a_in_ready;
        o_wr_en    = sel ? b_wr_en    : a_wr_en;
        o_wr_addr  = sel ? b_wr_addr  : a_wr_addr;
        o_wr_byte  = sel ? b_wr_byte  : a_wr_byte;
        o_busy     = sel ? b_busy     : a_busy;
        o_done     = sel ? b_done     : a_done;
        o_error    = sel ? b_error    : a_error;
        o_cnt      = sel ? b_cnt      : a_cnt;
        o_cpu_hold = sel ? b_cpu_hold : a_cpu_hold;
    end

    // Byte memory fed by the full-size instance only.
    always @(posedge clk)
        if (a_wr_en && a_wr_addr < 32'd400) mem[a_wr_addr[8:0]] <= a_wr_byte;

    function automatic logic [31:0] fetch(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_in_ready"}, o_in_ready, 1'b0);
        chk1({tag, "_wr_en"}, o_wr_en, 1'b0);
        chk({tag, "_wr_addr"}, o_wr_addr, 32'h0);
        chk({tag, "_wr_byte"}, 32'(o_wr_byte), 32'h0);
        chk1({tag, "_busy"}, o_busy, 1'b0);
        chk1({tag, "_done"}, o_done, 1'b0);
        chk1({tag, "_error"}, o_error, 1'b0);
        chk({tag, "_count"}, 32'(o_cnt), 32'h0);
        chk1({tag, "_cpu_hold"}, o_cpu_hold, 1'b1);
    endtask

    // Called at a negedge; returns at the negedge where the FSM sits in ACCEPT.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("start_cpu_hold", o_cpu_hold, 1'b1);
        chk1("start_busy", o_busy, 1'b1);
        chk1("start_in_ready", o_in_ready, 1'b1);
        chk("start_count", 32'(o_cnt), 32'h0);
        chk1("start_done", o_done, 1'b0);
        chk1("start_error", o_error, 1'b0);
    endtask

    // Offers one word after `gap` idle cycles and checks its four byte writes.
    // A start pulse is injected at beat sbeat (-1 for none).
    task automatic send_word(input logic [31:0] w, input logic l, input logic [31:0] a0,
                             input logic [3:0][7:0] eb, input int gap, input int sbeat);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_word = w; in_last = l;
        n = 0;
        while (!o_in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL hs_timeout: in_ready low for %0d cycles, required high", n);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == sbeat) start = 1'b1;
            chk1("beat_wr_en", o_wr_en, 1'b1);
            chk("beat_wr_addr", o_wr_addr, a0 + 32'(b));
            chk("beat_wr_byte", 32'(o_wr_byte), 32'(eb[b]));
            chk1("beat_in_ready", o_in_ready, 1'b0);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0]      word;
        logic             last;
        logic             new_load;
        logic [31:0]      addr;
        logic [3:0][7:0]  eb;
        logic [7:0]       exp_cnt;
        int               fetch_addr;
        logic [31:0]      fetch_exp;
    } vec_t;

    vec_t vecs [5];
    logic [31:0] bp [3];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0][7:0] eb;
        int rc, wc;
        logic hs;
        int idx;

        vecs[0] = '{32'h00500093, 1'b0, 1'b1, 32'd0, {8'h00, 8'h50, 8'h00, 8'h93}, 8'd1, 0, 32'h0};
        vecs[1] = '{32'h00A00113, 1'b1, 1'b0, 32'd4, {8'h00, 8'hA0, 8'h01, 8'h13}, 8'd2, 4, 32'h00A00113};
        vecs[2] = '{32'hDEADBEEF, 1'b0, 1'b1, 32'd0, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'd1, 0, 32'h0};
        vecs[3] = '{32'h12345678, 1'b0, 1'b0, 32'd4, {8'h12, 8'h34, 8'h56, 8'h78}, 8'd2, 0, 32'h0};
        vecs[4] = '{32'h80FF017F, 1'b1, 1'b0, 32'd8, {8'h80, 8'hFF, 8'h01, 8'h7F}, 8'd3, 8, 32'h80FF017F};
        bp[0] = 32'h11223344; bp[1] = 32'h55667788; bp[2] = 32'h99AABBCC;

        // Reset values on both instances.
        #2;
        sel = 1'b0; #1; chk_reset("rst_a");
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("rst_csum", a_csum, 32'h0);
`endif
        sel = 1'b1; #1; chk_reset("rst_b");
        sel = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven loads.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].new_load) do_start();
            send_word(vecs[i].word, vecs[i].last, vecs[i].addr, vecs[i].eb, 0, -1);
            chk("tbl_count", 32'(o_cnt), 32'(vecs[i].exp_cnt));
            if (vecs[i].last) begin
                chk1("tbl_done", o_done, 1'b1);
                chk1("tbl_cpu_hold", o_cpu_hold, 1'b0);
                chk1("tbl_busy", o_busy, 1'b0);
                chk1("tbl_in_ready", o_in_ready, 1'b0);
                chk("tbl_fetch", fetch(vecs[i].fetch_addr), vecs[i].fetch_exp);
            end else begin
                chk1("tbl_accept", o_in_ready, 1'b1);
            end
        end

        // DONE ignores in_valid.
        in_valid = 1'b1; in_word = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk1("done_ignore_wr", o_wr_en, 1'b0);
        chk("done_ignore_cnt", 32'(o_cnt), 32'd3);
        in_valid = 1'b0;

        // Backpressure: in_valid held high across three words.
        do_start();
        idx = 0; rc = 0; wc = 0;
        in_valid = 1'b1; in_word = bp[0]; in_last = 1'b0;
        for (int c = 0; c < 15; c++) begin
            hs = o_in_ready;
            if (o_in_ready) rc++;
            chk1("bp_ready", o_in_ready, (c % 5) == 0);
            if (o_wr_en) begin
                chk("bp_addr", o_wr_addr, 32'(wc));
                wc++;
            end
            @(negedge clk);
            if (hs) begin
                idx++;
                if (idx < 3) begin
                    in_word = bp[idx]; in_last = (idx == 2);
                end else begin
                    in_valid = 1'b0; in_last = 1'b0;
                end
            end
        end
        chk("bp_ready_cnt", 32'(rc), 32'd3);
        chk("bp_wr_cnt", 32'(wc), 32'd12);
        chk1("bp_done", o_done, 1'b1);
        chk("bp_mem0", fetch(0), 32'h11223344);
        chk("bp_mem1", fetch(4), 32'h55667788);
        chk("bp_mem2", fetch(8), 32'h99AABBCC);

        // Same image with idle gaps between words.
        do_start();
        for (int k = 0; k < 3; k++) begin
            eb = bp[k];
            send_word(bp[k], k == 2, 32'(4 * k), eb, (k == 0) ? 0 : ((k == 1) ? 3 : 7), -1);
        end
        chk1("gap_done", o_done, 1'b1);
        chk("gap_mem0", fetch(0), 32'h11223344);
        chk("gap_mem1", fetch(4), 32'h55667788);
        chk("gap_mem2", fetch(8), 32'h99AABBCC);

        // Overflow on the 8-byte instance.
        sel = 1'b1;
        @(negedge clk);
        do_start();
        send_word(32'hAABBCCDD, 1'b0, 32'd0, {8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0, -1);
        send_word(32'h01020304, 1'b0, 32'd4, {8'h01, 8'h02, 8'h03, 8'h04}, 0, -1);
        in_valid = 1'b1; in_word = 32'hCAFEF00D;
        chk1("ovf_ready", o_in_ready, 1'b1);
        @(negedge clk);
        chk1("ovf_error", o_error, 1'b1);
        chk1("ovf_done", o_done, 1'b0);
        chk1("ovf_cpu_hold", o_cpu_hold, 1'b1);
        chk("ovf_count", 32'(o_cnt), 32'd2);
        chk1("ovf_busy", o_busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk1("ovf_no_wr", o_wr_en, 1'b0);
            chk1("ovf_no_ready", o_in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        do_start();
        send_word(32'h0000_0001, 1'b0, 32'd0, {8'h00, 8'h00, 8'h00, 8'h01}, 0, -1);
        send_word(32'h0000_0002, 1'b1, 32'd4, {8'h00, 8'h00, 8'h00, 8'h02}, 0, -1);
        chk1("ovf_fit_done", o_done, 1'b1);
        chk1("ovf_fit_error", o_error, 1'b0);
        sel = 1'b0;
        @(negedge clk);

        // Reset during beat 2 of word 0.
        do_start();
        in_valid = 1'b1; in_word = 32'h0BADC0DE; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); @(negedge clk);
        chk1("mid_wr_before", o_wr_en, 1'b1);
        chk("mid_addr_before", o_wr_addr, 32'd2);
        reset = 1'b1;
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        chk("mid_partial0", 32'(mem[0]), 32'hDE);
        chk("mid_partial1", 32'(mem[1]), 32'hC0);
        chk("mid_untouched2", 32'(mem[2]), 32'h22);
        @(negedge clk);
        do_start();
        send_word(32'h13572468, 1'b1, 32'd0, {8'h13, 8'h57, 8'h24, 8'h68}, 0, -1);
        chk1("mid_restart_done", o_done, 1'b1);
        chk("mid_restart_cnt", 32'(o_cnt), 32'd1);
        chk("mid_restart_mem", fetch(0), 32'h13572468);

        // start while busy, in WRITE and in ACCEPT.
        do_start();
        send_word(32'h00000113, 1'b0, 32'd0, {8'h00, 8'h00, 8'h01, 8'h13}, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("busy_start_ready", o_in_ready, 1'b1);
        chk("busy_start_cnt", 32'(o_cnt), 32'd1);
        send_word(32'h00100193, 1'b1, 32'd4, {8'h00, 8'h10, 8'h01, 8'h93}, 0, 2);
        chk1("busy_start_done", o_done, 1'b1);
        chk("busy_start_cnt2", 32'(o_cnt), 32'd2);
        chk("busy_start_mem", fetch(4), 32'h00100193);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        chk("csum_clear", a_csum, 32'h0);
        send_word(32'hFFFFFFFF, 1'b0, 32'd0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, -1);
        send_word(32'h00000002, 1'b1, 32'd4, {8'h00, 8'h00, 8'h00, 8'h02}, 0, -1);
        chk1("csum_done", o_done, 1'b1);
        chk("csum_value", a_csum, 32'h00000001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
